// File: rtl/regfile_mp_pkg.sv
// Shared defaults and write-port priority for the regfile_mp register file.
package regfile_mp_pkg;

  localparam int unsigned DW_DEF    = 28;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned NRD_DEF   = 2;

  // On a same-register W0/W1 collision the ALU result (W0) is kept.
  localparam bit W0_WINS = 1'b1;

  // True when both ports target the same writable (nonzero) register.
  function automatic logic wr_same_dst(input logic en0, input logic en1,
                                       input logic [31:0] a0, input logic [31:0] a1);
    return en0 && en1 && (a0 == a1) && (a0 != 32'd0);
  endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Busy scoreboard: issue marks a destination pending, either writeback port clears it.
// With REGFILE_MP_BYPASS_EN, rd_busy hides a busy bit that is being cleared this cycle.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic              iss_ready,
  output logic [NRD-1:0]    rd_busy,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] set_vec, clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < DEPTH; i++) begin
      set_vec[i] = iss_en && (iss_addr == AW'(i)) && !busy_q[i];
      clr_vec[i] = (wr0_en && (wr0_addr == AW'(i))) || (wr1_en && (wr1_addr == AW'(i)));
    end
  end

  // Set beats clear: the issuing instruction is the newer producer.
  always_comb begin
    busy_d    = (busy_q & ~clr_vec) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign iss_ready = !busy_q[iss_addr];
  assign busy_vec  = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd_busy
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
`ifdef REGFILE_MP_BYPASS_EN
    assign rd_busy[k] = busy_q[a] && !(clr_vec[a] && !set_vec[a]);
`else
    assign rd_busy[k] = busy_q[a];
`endif
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write thread register file with integrated busy scoreboard; reg0 reads zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned NRD   = NRD_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr0_en,
  input  logic [AW-1:0]     wr0_addr,
  input  logic [DW-1:0]     wr0_data,
  input  logic              wr1_en,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [DW-1:0]     wr1_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              iss_ready,
  output logic              wr_collide,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DW-1:0] regs_q [DEPTH];
  logic          collide;
  logic          wr0_we, wr1_we;

  assign collide = wr_same_dst(wr0_en, wr1_en, 32'(wr0_addr), 32'(wr1_addr));
  // The losing port of a collision is suppressed; address 0 is never written.
  assign wr0_we  = wr0_en && (wr0_addr != '0) && !(collide && !W0_WINS);
  assign wr1_we  = wr1_en && (wr1_addr != '0) && !(collide && W0_WINS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_collide <= 1'b0;
    end else begin
      if (wr0_we) regs_q[wr0_addr] <= wr0_data;
      if (wr1_we) regs_q[wr1_addr] <= wr1_data;
      wr_collide <= collide;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] val;
    assign a = rd_addr[k*AW +: AW];
    always_comb begin
      val = (a == '0) ? '0 : regs_q[a];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr0_we && (wr0_addr == a)) begin
        val = wr0_data;
      end else if (wr1_we && (wr1_addr == a)) begin
        val = wr1_data;
      end
`endif
    end
    assign rd_data[k*DW +: DW] = val;
  end

  regfile_mp_sb #(
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .wr0_en    (wr0_en),
    .wr0_addr  (wr0_addr),
    .wr1_en    (wr1_en),
    .wr1_addr  (wr1_addr),
    .rd_addr   (rd_addr),
    .iss_ready (iss_ready),
    .rd_busy   (rd_busy),
    .busy_vec  (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (default DW=28, DEPTH=16, NRD=2).
module tb_regfile_mp;

  localparam int unsigned DW    = 28;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr0_en = 1'b0, wr1_en = 1'b0, iss_en = 1'b0;
  logic [AW-1:0]     wr0_addr = '0, wr1_addr = '0, iss_addr = '0;
  logic [DW-1:0]     wr0_data = '0, wr1_data = '0;
  logic              iss_ready, wr_collide;
  logic [DEPTH-1:0]  busy_vec;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .NRD   (NRD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .iss_ready  (iss_ready),
    .wr_collide (wr_collide),
    .busy_vec   (busy_vec)
  );

  // Expectations describe the outputs seen during the cycle, before that cycle's edge commits.
  typedef struct {
    logic          w0e;
    logic [3:0]    w0a;
    logic [27:0]   w0d;
    logic          w1e;
    logic [3:0]    w1a;
    logic [27:0]   w1d;
    logic          ie;
    logic [3:0]    ia;
    logic [3:0]    ra0;
    logic [3:0]    ra1;
    logic [27:0]   e_rd0;
    logic [27:0]   e_rd1;
    logic [15:0]   e_bv;
    logic [1:0]    e_rdb;
    logic          e_rdy;
    logic          e_col;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic w0e, logic [3:0] w0a, logic [27:0] w0d,
                              logic w1e, logic [3:0] w1a, logic [27:0] w1d,
                              logic ie, logic [3:0] ia, logic [3:0] ra0, logic [3:0] ra1,
                              logic [27:0] e_rd0, logic [27:0] e_rd1, logic [15:0] e_bv,
                              logic [1:0] e_rdb, logic e_rdy, logic e_col);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_bv = e_bv;
    v.e_rdb = e_rdb; v.e_rdy = e_rdy; v.e_col = e_col;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    iss_en = 1'b0;
  endtask

  initial begin
    logic [27:0] exp_byp;

    //               w0e w0a  w0d          w1e w1a  w1d          ie  ia  ra0 ra1  rd0          rd1          busy_vec rdb    rdy col
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 0, 3, 5,  28'h0,       28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(1, 3, 28'hABCDEF0,  0, 0, 28'h0,        0, 0, 1, 2,  28'h0,       28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(1, 0, 28'hFFFFFFF,  0, 0, 28'h0,        0, 0, 3, 0,  28'hABCDEF0, 28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 0, 0, 3,  28'h0,       28'hABCDEF0, 16'h0,   2'b00, 1, 0));
    vq.push_back(mk(1, 7, 28'h0000011,  1, 7, 28'h0000022,  0, 0, 3, 3,  28'hABCDEF0, 28'hABCDEF0, 16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 0, 7, 0,  28'h0000011, 28'h0,       16'h0,   2'b00, 1, 1));
    vq.push_back(mk(1, 0, 28'h0000001,  1, 0, 28'h0000002,  0, 0, 7, 7,  28'h0000011, 28'h0000011, 16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 0, 0, 7,  28'h0,       28'h0000011, 16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        1, 9, 9, 3,  28'h0,       28'hABCDEF0, 16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        1, 9, 9, 1,  28'h0,       28'h0,       16'h0200, 2'b01, 0, 0));
    vq.push_back(mk(0, 0, 28'h0,        1, 9, 28'h0000099,  0, 9, 1, 2,  28'h0,       28'h0,       16'h0200, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 9, 9, 0,  28'h0000099, 28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        1, 4, 1, 2,  28'h0,       28'h0,       16'h0,   2'b00, 1, 0));
    // reg4 busy: the issue is refused (not ready), so only the writeback's clear applies
    vq.push_back(mk(1, 4, 28'h0000044,  0, 0, 28'h0,        1, 4, 1, 2,  28'h0,       28'h0,       16'h0010, 2'b00, 0, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 4, 4, 0,  28'h0000044, 28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        1, 4, 28'h0000055,  1, 4, 1, 2,  28'h0,       28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 4, 4, 0,  28'h0000055, 28'h0,       16'h0010, 2'b01, 0, 0));
    vq.push_back(mk(1, 4, 28'h0000066,  0, 0, 28'h0,        0, 4, 1, 2,  28'h0,       28'h0,       16'h0010, 2'b00, 0, 0));
    vq.push_back(mk(1, 5, 28'h1234567,  0, 0, 28'h0,        0, 4, 4, 0,  28'h0000066, 28'h0,       16'h0,   2'b00, 1, 0));
    vq.push_back(mk(1, 6, 28'h0000006,  1, 8, 28'h0000008,  0, 0, 5, 4,  28'h1234567, 28'h0000066, 16'h0,   2'b00, 1, 0));
    vq.push_back(mk(0, 0, 28'h0,        0, 0, 28'h0,        0, 0, 6, 8,  28'h0000006, 28'h0000008, 16'h0,   2'b00, 1, 0));

    #12 rst_n = 1'b1;

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      wr0_en = vq[i].w0e; wr0_addr = vq[i].w0a; wr0_data = vq[i].w0d;
      wr1_en = vq[i].w1e; wr1_addr = vq[i].w1a; wr1_data = vq[i].w1d;
      iss_en = vq[i].ie;  iss_addr = vq[i].ia;
      rd_addr = {vq[i].ra1, vq[i].ra0};
      @(negedge clk);
      chk($sformatf("v%0d rd0", i), 32'(rd_data[0 +: DW]), 32'(vq[i].e_rd0));
      chk($sformatf("v%0d rd1", i), 32'(rd_data[DW +: DW]), 32'(vq[i].e_rd1));
      chk($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vq[i].e_bv));
      chk($sformatf("v%0d rd_busy", i), 32'(rd_busy), 32'(vq[i].e_rdb));
      chk($sformatf("v%0d iss_ready", i), 32'(iss_ready), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d wr_collide", i), 32'(wr_collide), 32'(vq[i].e_col));
    end

    // Same-cycle read of a register being written: forwarded only with the bypass build.
`ifdef REGFILE_MP_BYPASS_EN
    exp_byp = 28'h5555555;
`else
    exp_byp = 28'h0;
`endif
    @(posedge clk);
    #1;
    drive_idle();
    wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 28'h5555555;
    rd_addr = {4'd2, 4'd6};
    @(negedge clk);
    chk("byp same-cycle rd1", 32'(rd_data[DW +: DW]), 32'(exp_byp));
    chk("byp other port rd0", 32'(rd_data[0 +: DW]), 32'h0000006);
    @(posedge clk);
    #1;
    drive_idle();
    @(negedge clk);
    chk("byp next-cycle rd1", 32'(rd_data[DW +: DW]), 32'h5555555);

    // Async reset mid-cycle with a write and an issue in flight (reg5 holds 0x1234567).
    @(posedge clk);
    #1;
    wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 28'h7777777;
    iss_en = 1'b1; iss_addr = 4'd10;
    rd_addr = {4'd6, 4'd5};
    #2 rst_n = 1'b0;
    #1;
    chk("rst reg5", 32'(rd_data[0 +: DW]), 32'h0);
    chk("rst reg6", 32'(rd_data[DW +: DW]), 32'h0);
    chk("rst busy_vec", 32'(busy_vec), 32'h0);
    chk("rst iss_ready", 32'(iss_ready), 32'h1);
    chk("rst rd_busy", 32'(rd_busy), 32'h0);
    chk("rst wr_collide", 32'(wr_collide), 32'h0);
    @(posedge clk);
    #1;
    chk("rst held reg5", 32'(rd_data[0 +: DW]), 32'h0);
    chk("rst held busy_vec", 32'(busy_vec), 32'h0);
    drive_idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst reg5", 32'(rd_data[0 +: DW]), 32'h0);
    chk("post-rst busy_vec", 32'(busy_vec), 32'h0);
    chk("post-rst iss_ready", 32'(iss_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
